// File: rtl/scaler_sched.sv
// Frame scheduler for a shared scaler: one channel at a time is sent to the scaler,
// its result is collected, and the completed frame is published on out_data.
module scaler_sched #(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_valid,
    input  logic [8*NUM_CH-1:0]    frame_data,
    input  logic [8*NUM_CH-1:0]    frame_offset,
    output logic                   scl_sink_data_valid,
    output logic [7:0]             scl_sink_data,
    output logic [7:0]             scl_sink_offset,
    input  logic                   scl_source_data_valid,
    input  logic [14:0]            scl_source_data,
    output logic [15*NUM_CH-1:0]   out_data,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   err_overrun,
    output logic                   err_timeout
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       wait_cnt_q;
    logic [8*NUM_CH-1:0]    data_q;
    logic [8*NUM_CH-1:0]    offset_q;
    logic [15*NUM_CH-1:0]   shadow_q;
    logic [15*NUM_CH-1:0]   out_data_q;
    logic                   sink_valid_q;
    logic [7:0]             sink_data_q;
    logic [7:0]             sink_offset_q;
    logic                   out_valid_q;
    logic                   err_overrun_q;
    logic                   err_timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            wait_cnt_q    <= '0;
            // NOTE: the frame and shadow storage are plain flops here, so resetting them is
            // cheap and keeps every output deterministic after reset.
            data_q        <= '0;
            offset_q      <= '0;
            shadow_q      <= '0;
            out_data_q    <= '0;
            sink_valid_q  <= 1'b0;
            sink_data_q   <= '0;
            sink_offset_q <= '0;
            out_valid_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle and are raised only by the state that owns them.
            sink_valid_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;

            // Any frame outside IDLE, including the DONE cycle, is dropped and flagged.
            if (frame_valid && state_q != S_IDLE) begin
                err_overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (frame_valid) begin
                        data_q   <= frame_data;
                        offset_q <= frame_offset;
                        idx_q    <= '0;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sink_valid_q  <= 1'b1;
                    sink_data_q   <= data_q[idx_q*8 +: 8];
                    sink_offset_q <= offset_q[idx_q*8 +: 8];
                    wait_cnt_q    <= '0;
                    state_q       <= S_WAIT;
                end
                S_WAIT: begin
                    if (scl_source_data_valid) begin
                        shadow_q[idx_q*15 +: 15] <= scl_source_data;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= S_ISSUE;
                        end
                    end else if (wait_cnt_q == CNT_LAST) begin
                        // The TIMEOUT_CYC-th empty wait cycle abandons the frame.
                        err_timeout_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    out_data_q  <= shadow_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign scl_sink_data_valid = sink_valid_q;
    assign scl_sink_data       = sink_data_q;
    assign scl_sink_offset     = sink_offset_q;
    assign out_data            = out_data_q;
    assign out_valid           = out_valid_q;
    assign busy                = (state_q != S_IDLE);
    assign err_overrun         = err_overrun_q;
    assign err_timeout         = err_timeout_q;

endmodule

// File: doc/scaler_sched.md
SCALER_SCHED -- requirements
Module: scaler_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: channels per frame (roll, pitch, yaw, throttle order, ch0 first).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 15: maximum cycles to wait for a scaler result.
REQ-003 SHALL have port clk, input, 1: the only clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port frame_valid, input, 1: single-cycle strobe; frame_data and frame_offset are valid.
REQ-006 SHALL have port frame_data, input, 8*NUM_CH: channel bytes, ch0 in [7:0].
REQ-007 SHALL have port frame_offset, input, 8*NUM_CH: per-channel offsets, ch0 in [7:0].
REQ-008 SHALL have port scl_sink_data_valid, output, 1: request strobe to the shared scaler.
REQ-009 SHALL have ports scl_sink_data and scl_sink_offset, outputs, 8 each: operands to the scaler.
REQ-010 SHALL have port scl_source_data_valid, input, 1: scaler result strobe.
REQ-011 SHALL have port scl_source_data, input, 15: scaler result.
REQ-012 SHALL have port out_data, output, 15*NUM_CH: scaled frame, ch0 in [14:0].
REQ-013 SHALL have port out_valid, output, 1: one-cycle strobe; out_data holds a complete new frame.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port err_overrun, output, 1: sticky; a frame_valid arrived while busy.
REQ-016 SHALL have port err_timeout, output, 1: one-cycle pulse; a scaler result did not arrive in time.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-018 IDLE with frame_valid=1 SHALL latch frame_data and frame_offset, clear the channel index to 0, and go to ISSUE.
REQ-019 ISSUE SHALL register scl_sink_data_valid=1 for exactly one cycle, with the byte and offset of the current index, clear the wait counter, and go to WAIT.
REQ-020 WAIT with scl_source_data_valid=1 SHALL store scl_source_data into the out_data slot of the current index.
REQ-021 After that store, WAIT SHALL go to DONE if the index equals NUM_CH-1; otherwise it SHALL increment the index and go to ISSUE.
REQ-022 WAIT without a result SHALL increment the wait counter.
REQ-023 When the wait counter reaches TIMEOUT_CYC, the block SHALL pulse err_timeout, discard the frame, leave out_data unchanged, keep out_valid low, and return to IDLE.
REQ-024 DONE SHALL copy the shadow results to out_data, pulse out_valid for 1 cycle, and return to IDLE; out_data SHALL change only in DONE.
REQ-025 With a 1-cycle scaler, out_valid SHALL rise exactly 2*NUM_CH+1 cycles after the edge that sampled frame_valid (9 cycles for NUM_CH=4).
REQ-026 frame_valid while busy=1 SHALL be dropped and SHALL set err_overrun; it SHALL NOT corrupt the frame in progress.
REQ-027 frame_valid in the same cycle as the DONE to IDLE transition SHALL be dropped and SHALL set err_overrun; it is accepted only in IDLE.
REQ-028 scl_source_data_valid outside WAIT SHALL be ignored, including late results after a timeout.
REQ-029 The block SHALL NOT modify result values; 15-bit wrap of (data+offset-128)*48 belongs to the scaler.
REQ-030 scl_sink_data and scl_sink_offset SHALL hold their last value while scl_sink_data_valid=0.
REQ-031 err_overrun SHALL clear only on reset.

Reset
REQ-032 Asserting reset (low) at any time, including mid-frame, SHALL immediately force: state IDLE, index 0, wait counter 0, scl_sink_data_valid 0, scl_sink_data 0, scl_sink_offset 0, out_data 0, out_valid 0, busy 0, err_overrun 0, err_timeout 0.
REQ-033 After reset release, the first frame_valid SHALL be accepted normally.

Verification (NUM_CH=4, real scaler attached)
REQ-034 Bench SHALL drive data {0x80,0x81,0x90,0xFF} with offsets {0,0,0x10,0} -> out_valid 9 cycles later; out_data slots = {0, 48, 1536, 6096}.
REQ-035 Bench SHALL drive a second frame_valid 3 cycles after the first -> err_overrun=1 and first frame results intact; an immediate third frame in IDLE -> accepted.
REQ-036 Bench SHALL hold scl_source_data_valid low for channel 2 (stubbed scaler) -> err_timeout pulse after 15 WAIT cycles, no out_valid, out_data unchanged, busy=0.
REQ-037 Bench SHALL drive frame_valid on the DONE cycle -> dropped, err_overrun=1.
REQ-038 Bench SHALL assert reset mid-WAIT of channel 1 -> all outputs 0 asynchronously; a new frame after release completes in 9 cycles.
REQ-039 Bench SHALL inject a spurious scl_source_data_valid with value 0x1234 in IDLE -> out_data and out_valid unaffected.
